// File: rtl/fat_pkg.sv
// Shared definitions for the FAT32 chain-rebuild sequencer: state encoding,
// sector geometry and FAT32 constants.
package fat_pkg;

    localparam int          ENTRIES_PER_SECTOR = 128;
    localparam int          ENTRY_SHIFT        = $clog2(ENTRIES_PER_SECTOR);
    localparam logic [31:0] FAT32_EOF_MARK     = 32'hFFFF_FFFF;
    localparam int          SECTOR_BYTES       = 512;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_FILL,
        ST_DRAIN,
        ST_WRITE,
        ST_NEXT,
        ST_FIN,
        ST_FAIL
`ifdef FAT_MIRROR_EN
        , ST_MIRROR
`endif
    } seq_state_t;

endpackage

// File: rtl/fat_chain_sequencer_if.sv
// Bus bundle between the file-close controller / fill stage / sector writer
// (master side) and the chain sequencer (slave side).
interface fat_chain_sequencer_if;

    logic        START;
    logic [31:0] FIRST_CLUST;
    logic [31:0] CLUST_COUNT;
    logic [31:0] FAT_BEGIN_LBA;
    logic        UPD_ENA;
    logic [31:0] UPD_BEGIN_CLUST;
    logic [31:0] UPD_EOF_CLUST;
    logic        UPD_COMPLT;
    logic        WR_REQ;
    logic [31:0] WR_LBA;
    logic        WR_ACK;
    logic        WR_ERR;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;

    modport master (
        output START, FIRST_CLUST, CLUST_COUNT, FAT_BEGIN_LBA,
        output UPD_COMPLT, WR_ACK, WR_ERR,
        input  UPD_ENA, UPD_BEGIN_CLUST, UPD_EOF_CLUST,
        input  WR_REQ, WR_LBA, BUSY, DONE, ERROR
    );

    modport slave (
        input  START, FIRST_CLUST, CLUST_COUNT, FAT_BEGIN_LBA,
        input  UPD_COMPLT, WR_ACK, WR_ERR,
        output UPD_ENA, UPD_BEGIN_CLUST, UPD_EOF_CLUST,
        output WR_REQ, WR_LBA, BUSY, DONE, ERROR
    );

endinterface

// File: rtl/fat_sector_span.sv
// Derives the EOF cluster and first/last FAT sector index of a contiguous chain;
// combinational values for the accepting cycle, latched copies afterwards.
module fat_sector_span #(
    parameter int SHIFT = fat_pkg::ENTRY_SHIFT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_first_clust,
    input  logic [31:0] i_clust_count,
    output logic [31:0] o_eof_now,
    output logic [31:0] o_first_sec_now,
    output logic [31:0] o_eof,
    output logic [31:0] o_last_sec
);

    logic [31:0] w_eof;
    logic [31:0] w_last_sec;
    logic [31:0] r_eof;
    logic [31:0] r_last_sec;

    // EOF is allowed to wrap; the last sector holds cluster EOF-1
    assign w_eof      = i_first_clust + i_clust_count;
    assign w_last_sec = (w_eof - 32'd1) >> SHIFT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_eof      <= '0;
            r_last_sec <= '0;
        end else if (i_load) begin
            r_eof      <= w_eof;
            r_last_sec <= w_last_sec;
        end
    end

    assign o_eof_now       = w_eof;
    assign o_first_sec_now = i_first_clust >> SHIFT;
    assign o_eof           = r_eof;
    assign o_last_sec      = r_last_sec;

endmodule

// File: rtl/fat_chain_sequencer.sv
// Rebuilds a contiguous FAT32 cluster chain one FAT sector at a time: arm fill
// stage, wait for fill, write sector. Define FAT_MIRROR_EN to also write each
// sector to the second FAT copy at LBA + FAT_SIZE_SECTORS.
module fat_chain_sequencer #(
    parameter int          ENTRIES_PER_SECTOR = fat_pkg::ENTRIES_PER_SECTOR,
    parameter logic [31:0] FAT_SIZE_SECTORS   = 32'd1024
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    fat_chain_sequencer_if.slave bus
);
    import fat_pkg::*;

    localparam int SHIFT = $clog2(ENTRIES_PER_SECTOR);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_sec;
    logic [31:0] r_fat_lba;

    logic        r_upd_ena,   w_upd_ena_next;
    logic [31:0] r_upd_begin, w_upd_begin_next;
    logic [31:0] r_upd_eof,   w_upd_eof_next;
    logic        r_wr_req,    w_wr_req_next;
    logic [31:0] r_wr_lba,    w_wr_lba_next;
    logic        r_busy,      w_busy_next;
    logic        r_done,      w_done_next;
    logic        r_error,     w_error_next;

    logic        w_accept;
    logic        w_load_sector;
    logic [31:0] w_sec_sel;
    logic [31:0] w_eof_sel;
    logic [31:0] w_lba_base;
    logic [31:0] w_eof_now;
    logic [31:0] w_first_sec_now;
    logic [31:0] w_eof;
    logic [31:0] w_last_sec;

    assign w_accept = (r_state == ST_IDLE) && bus.START;

    fat_sector_span #(
        .SHIFT (SHIFT)
    ) u_span (
        .i_clk           (CLK),
        .i_rst_n         (RST_N),
        .i_load          (w_accept),
        .i_first_clust   (bus.FIRST_CLUST),
        .i_clust_count   (bus.CLUST_COUNT),
        .o_eof_now       (w_eof_now),
        .o_first_sec_now (w_first_sec_now),
        .o_eof           (w_eof),
        .o_last_sec      (w_last_sec)
    );

    // r_cnt restarts on every state change; ARM and DRAIN each last two cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? 2'd0 : r_cnt + 2'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.START)
                    w_state_next = (bus.CLUST_COUNT == 32'd0) ? ST_FIN : ST_ARM;
            end
            ST_ARM:   if (r_cnt == 2'd1) w_state_next = ST_FILL;
            ST_FILL:  if (bus.UPD_COMPLT) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_cnt == 2'd1) w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (bus.WR_ERR)
                    w_state_next = ST_FAIL;
                else if (bus.WR_ACK)
`ifdef FAT_MIRROR_EN
                    w_state_next = ST_MIRROR;
`else
                    w_state_next = ST_NEXT;
`endif
            end
`ifdef FAT_MIRROR_EN
            ST_MIRROR: begin
                if (bus.WR_ERR)
                    w_state_next = ST_FAIL;
                else if (bus.WR_ACK)
                    w_state_next = ST_NEXT;
            end
`endif
            ST_NEXT:  w_state_next = (r_sec == w_last_sec) ? ST_FIN : ST_ARM;
            ST_FIN:   w_state_next = ST_IDLE;
            ST_FAIL:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Sector parameters come from the live inputs on START, from latched state on NEXT
    assign w_sec_sel     = (r_state == ST_IDLE) ? w_first_sec_now   : r_sec + 32'd1;
    assign w_eof_sel     = (r_state == ST_IDLE) ? w_eof_now         : w_eof;
    assign w_lba_base    = (r_state == ST_IDLE) ? bus.FAT_BEGIN_LBA : r_fat_lba;
    assign w_load_sector = (w_state_next == ST_ARM) && (r_state != ST_ARM);

    always_comb begin
        w_upd_begin_next = r_upd_begin;
        w_upd_eof_next   = r_upd_eof;
        w_wr_lba_next    = r_wr_lba;
        w_upd_ena_next   = (w_state_next == ST_FILL) || (w_state_next == ST_DRAIN);
        w_wr_req_next    = (w_state_next == ST_WRITE);
        w_busy_next      = !(w_state_next inside {ST_IDLE, ST_FIN, ST_FAIL});
        w_done_next      = (w_state_next == ST_FIN);
        w_error_next     = r_error;
        if (w_load_sector) begin
            w_upd_begin_next = (w_sec_sel << SHIFT) + 32'd1;
            w_upd_eof_next   = w_eof_sel;
            w_wr_lba_next    = w_lba_base + w_sec_sel;
        end
`ifdef FAT_MIRROR_EN
        if (w_state_next == ST_MIRROR) begin
            w_wr_req_next = 1'b1;
            if (r_state == ST_WRITE)
                w_wr_lba_next = r_wr_lba + FAT_SIZE_SECTORS;
        end
`endif
        if (w_accept)
            w_error_next = 1'b0;
        else if (w_state_next == ST_FAIL)
            w_error_next = 1'b1;
    end

`ifndef FAT_MIRROR_EN
    logic w_unused_fat_size;
    assign w_unused_fat_size = ^FAT_SIZE_SECTORS;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_upd_ena   <= 1'b0;
            r_upd_begin <= '0;
            r_upd_eof   <= '0;
            r_wr_req    <= 1'b0;
            r_wr_lba    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_sec       <= '0;
            r_fat_lba   <= '0;
        end else begin
            r_upd_ena   <= w_upd_ena_next;
            r_upd_begin <= w_upd_begin_next;
            r_upd_eof   <= w_upd_eof_next;
            r_wr_req    <= w_wr_req_next;
            r_wr_lba    <= w_wr_lba_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_error     <= w_error_next;
            if (w_load_sector)
                r_sec <= w_sec_sel;
            if (w_accept)
                r_fat_lba <= bus.FAT_BEGIN_LBA;
        end
    end

    assign bus.UPD_ENA         = r_upd_ena;
    assign bus.UPD_BEGIN_CLUST = r_upd_begin;
    assign bus.UPD_EOF_CLUST   = r_upd_eof;
    assign bus.WR_REQ          = r_wr_req;
    assign bus.WR_LBA          = r_wr_lba;
    assign bus.BUSY            = r_busy;
    assign bus.DONE            = r_done;
    assign bus.ERROR           = r_error;

endmodule

// File: tb/tb_fat_chain_sequencer.sv
// Scoreboard bench for fat_chain_sequencer: a chain-level model queues the
// expected fill/write/end events, a monitor pops them as the DUT shows them.
module tb_fat_chain_sequencer;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    fat_chain_sequencer_if bus ();

    fat_chain_sequencer #(
        .ENTRIES_PER_SECTOR (128),
        .FAT_SIZE_SECTORS   (32'd1024)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam longint EPS = 128;
    localparam longint FSZ = 1024;
`ifdef FAT_MIRROR_EN
    localparam int COPIES = 2;
`else
    localparam int COPIES = 1;
`endif

    typedef enum {EV_FILL, EV_WRITE, EV_DONE, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] begin_cl;
        logic [31:0] eof_cl;
        logic [31:0] lba;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  err_on_write = -1;
    int  write_idx    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit pop_ev(ev_kind_t k, output ev_t e);
        total++;
        e = '{EV_DONE, 32'd0, 32'd0, 32'd0};
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got event, expected nothing", k.name());
            return 0;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            bad++;
            $display("FAIL event_order: got %s, expected %s", k.name(), e.kind.name());
            return 0;
        end
        return 1;
    endfunction

    // Chain-level reference: every sector touched by [first, first+count) gets one
    // fill and COPIES writes; the first failing write aborts the chain.
    function automatic bit model_op(logic [31:0] first, logic [31:0] count,
                                    logic [31:0] lba, int err);
        logic [31:0] eof;
        longint      s, l;
        int          widx;
        eof = first + count;
        if (count == 0) begin
            exp_q.push_back('{EV_DONE, 32'd0, 32'd0, 32'd0});
            return 0;
        end
        s    = longint'(first) / EPS;
        l    = (longint'(eof) - 1) / EPS;
        widx = 0;
        for (longint sec = s; sec <= l; sec++) begin
            logic [31:0] b;
            b = 32'(sec * EPS + 1);
            exp_q.push_back('{EV_FILL, b, eof, 32'd0});
            for (int c = 0; c < COPIES; c++) begin
                exp_q.push_back('{EV_WRITE, b, eof, 32'(longint'(lba) + sec + c * FSZ)});
                if (widx == err) begin
                    exp_q.push_back('{EV_ERROR, 32'd0, 32'd0, 32'd0});
                    return 1;
                end
                widx++;
            end
        end
        exp_q.push_back('{EV_DONE, 32'd0, 32'd0, 32'd0});
        return 0;
    endfunction

    // Fill stage: completes after a random delay; stray completions while disabled
    initial begin : fill_resp
        int dly;
        bit fired;
        dly   = -1;
        fired = 0;
        bus.UPD_COMPLT = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.UPD_COMPLT = 1'b0;
            if (bus.UPD_ENA) begin
                if (!fired) begin
                    if (dly < 0) dly = $urandom_range(0, 4);
                    if (dly == 0) begin
                        bus.UPD_COMPLT = 1'b1;
                        fired = 1;
                        dly   = -1;
                    end else begin
                        dly--;
                    end
                end
            end else begin
                fired = 0;
                dly   = -1;
                if ($urandom_range(0, 7) == 0) bus.UPD_COMPLT = 1'b1;
            end
        end
    end

    // Sector writer: acks after a random delay, injects the selected error,
    // and throws stray ack/err pulses while no write is requested
    initial begin : wr_resp
        int dly;
        dly = -1;
        bus.WR_ACK = 1'b0;
        bus.WR_ERR = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.WR_ACK = 1'b0;
            bus.WR_ERR = 1'b0;
            if (bus.WR_REQ) begin
                if (dly < 0) dly = $urandom_range(0, 3);
                if (dly == 0) begin
                    if (write_idx == err_on_write) begin
                        bus.WR_ERR = 1'b1;
                        bus.WR_ACK = 1'($urandom_range(0, 1));
                    end else begin
                        bus.WR_ACK = 1'b1;
                    end
                    write_idx++;
                    dly = -1;
                end else begin
                    dly--;
                end
            end else begin
                dly = -1;
                case ($urandom_range(0, 9))
                    0: bus.WR_ACK = 1'b1;
                    1: bus.WR_ERR = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    initial begin : monitor
        logic prev_req, prev_ack, prev_ena, prev_err;
        int   drain_cnt;
        ev_t  e;
        prev_req = 0; prev_ack = 0; prev_ena = 0; prev_err = 0;
        drain_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_req = 0; prev_ack = 0; prev_ena = 0; prev_err = 0;
                drain_cnt = 0;
                continue;
            end
            if (drain_cnt > 0) begin
                if (drain_cnt > 1) begin
                    check("drain_ena_held", 32'(bus.UPD_ENA), 32'd1);
                end else begin
                    check("drain_ena_drop", 32'(bus.UPD_ENA), 32'd0);
                    check("drain_wr_req_rise", 32'(bus.WR_REQ), 32'd1);
                end
                drain_cnt--;
            end
            if (bus.UPD_COMPLT && bus.UPD_ENA && drain_cnt == 0) drain_cnt = 3;
            if (bus.UPD_ENA && !prev_ena) begin
                $display("[%0t] FILL  begin=%0d eof=%0d", $time, bus.UPD_BEGIN_CLUST, bus.UPD_EOF_CLUST);
                if (pop_ev(EV_FILL, e)) begin
                    check("fill_begin_clust", bus.UPD_BEGIN_CLUST, e.begin_cl);
                    check("fill_eof_clust", bus.UPD_EOF_CLUST, e.eof_cl);
                end
            end
            if (bus.WR_REQ && (!prev_req || prev_ack)) begin
                $display("[%0t] WRITE lba=%0d begin=%0d eof=%0d", $time, bus.WR_LBA,
                         bus.UPD_BEGIN_CLUST, bus.UPD_EOF_CLUST);
                if (pop_ev(EV_WRITE, e)) begin
                    check("write_lba", bus.WR_LBA, e.lba);
                    check("write_begin_stable", bus.UPD_BEGIN_CLUST, e.begin_cl);
                    check("write_eof_stable", bus.UPD_EOF_CLUST, e.eof_cl);
                    check("write_ena_low", 32'(bus.UPD_ENA), 32'd0);
                end
            end
            if (bus.DONE) begin
                $display("[%0t] DONE", $time);
                if (pop_ev(EV_DONE, e)) check("done_busy_low", 32'(bus.BUSY), 32'd0);
            end
            if (bus.ERROR && !prev_err) begin
                $display("[%0t] ERROR", $time);
                if (pop_ev(EV_ERROR, e)) check("error_busy_low", 32'(bus.BUSY), 32'd0);
            end
            prev_req = bus.WR_REQ;
            prev_ack = bus.WR_ACK;
            prev_ena = bus.UPD_ENA;
            prev_err = bus.ERROR;
        end
    end

    task automatic start_op(input logic [31:0] first, input logic [31:0] count,
                            input logic [31:0] lba, input int err, output bit exp_err);
        exp_err      = model_op(first, count, lba, err);
        err_on_write = err;
        write_idx    = 0;
        @(posedge CLK);
        #1;
        bus.START         = 1'b1;
        bus.FIRST_CLUST   = first;
        bus.CLUST_COUNT   = count;
        bus.FAT_BEGIN_LBA = lba;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        @(negedge CLK);
        check("start_clears_error", 32'(bus.ERROR), 32'd0);
        if (count == 0) begin
            check("zero_done_next_cycle", 32'(bus.DONE), 32'd1);
            check("zero_busy", 32'(bus.BUSY), 32'd0);
            check("zero_ena", 32'(bus.UPD_ENA), 32'd0);
        end else begin
            check("start_busy", 32'(bus.BUSY), 32'd1);
            check("arm1_ena", 32'(bus.UPD_ENA), 32'd0);
            @(negedge CLK);
            check("arm2_ena", 32'(bus.UPD_ENA), 32'd0);
            @(negedge CLK);
            check("fill_ena_rise", 32'(bus.UPD_ENA), 32'd1);
        end
    endtask

    task automatic finish_op(input bit exp_err);
        int budget;
        budget = 0;
        while (bus.BUSY && budget < 5000) begin
            @(negedge CLK);
            budget++;
        end
        check("busy_drop_in_time", 32'(budget < 5000), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("error_flag", 32'(bus.ERROR), 32'(exp_err));
        exp_q.delete();
    endtask

    task automatic run_op(input logic [31:0] first, input logic [31:0] count,
                          input logic [31:0] lba, input int err);
        bit exp_err;
        start_op(first, count, lba, err, exp_err);
        finish_op(exp_err);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit ee;
        bus.START         = 1'b0;
        bus.FIRST_CLUST   = 32'd0;
        bus.CLUST_COUNT   = 32'd0;
        bus.FAT_BEGIN_LBA = 32'd0;
        repeat (3) @(negedge CLK);
        check("rst_upd_ena", 32'(bus.UPD_ENA), 32'd0);
        check("rst_upd_begin", bus.UPD_BEGIN_CLUST, 32'd0);
        check("rst_upd_eof", bus.UPD_EOF_CLUST, 32'd0);
        check("rst_wr_req", 32'(bus.WR_REQ), 32'd0);
        check("rst_wr_lba", bus.WR_LBA, 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_error", 32'(bus.ERROR), 32'd0);
        #2 RST_N = 1'b1;

        run_op(32'd2,   32'd10, 32'd100, -1);
        run_op(32'd120, 32'd20, 32'd100, -1);
        run_op(32'd5,   32'd0,  32'd100, -1);
        run_op(32'd2,   32'd10, 32'd100, 0);
        run_op(32'd2,   32'd10, 32'd100, -1);

        // START while busy must not disturb the running chain
        start_op(32'd120, 32'd20, 32'd100, -1, ee);
        @(posedge CLK);
        #1;
        bus.START       = 1'b1;
        bus.FIRST_CLUST = 32'd5000;
        bus.CLUST_COUNT = 32'd3;
        @(posedge CLK);
        #1;
        bus.START       = 1'b0;
        bus.FIRST_CLUST = 32'd120;
        bus.CLUST_COUNT = 32'd20;
        finish_op(ee);

        // Asynchronous reset while the fill stage is enabled
        start_op(32'd2, 32'd300, 32'd50, -1, ee);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_ena", 32'(bus.UPD_ENA), 32'd0);
        check("async_rst_busy", 32'(bus.BUSY), 32'd0);
        check("async_rst_wr_req", 32'(bus.WR_REQ), 32'd0);
        check("async_rst_begin", bus.UPD_BEGIN_CLUST, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        run_op(32'd130, 32'd200, 32'd7, -1);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] f, c, l;
            int          e;
            f = $urandom_range(2, 3000);
            c = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 400));
            l = $urandom_range(0, 100000);
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_op(f, c, l, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fat_chain_sequencer.md
# fat_chain_sequencer

Sequences the rebuild of a contiguous FAT32 cluster chain, one FAT sector at a time. For each sector it arms the FAT-sector fill stage with the correct begin-cluster and EOF-cluster values and waits for that stage to finish filling the sector buffer. It then requests the sector write at the right LBA and advances to the next sector. It sits upstream of the fill stage and alongside the sector writer, driven by the file-close controller.

## Interface
Parameters:
- ENTRIES_PER_SECTOR, 128: FAT32 entries per 512-byte sector; power of two.
- FAT_SIZE_SECTORS, 32'd1024: sectors per FAT copy; used only with mirroring.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle request; sampled only in IDLE.
- FIRST_CLUST  in  32  first cluster of the chain (≥2).
- CLUST_COUNT  in  32  clusters in the chain.
- FAT_BEGIN_LBA  in  32  LBA of FAT sector 0.
- UPD_ENA  out  1  enable to the fill stage.
- UPD_BEGIN_CLUST  out  32  begin-cluster value for the current sector.
- UPD_EOF_CLUST  out  32  EOF-cluster value.
- UPD_COMPLT  in  1  fill-stage completion flag.
- WR_REQ  out  1  sector-write request; level, held until WR_ACK.
- WR_LBA  out  32  target LBA; stable while WR_REQ=1.
- WR_ACK  in  1  one-cycle write-done pulse.
- WR_ERR  in  1  one-cycle write-failure pulse; may replace WR_ACK.
- BUSY  out  1  high from START acceptance until DONE or ERROR.
- DONE  out  1  one-cycle pulse at successful end.
- ERROR  out  1  sticky; cleared by the next accepted START or by reset.

## Operation
- On START, latch the following:
  - EOF = FIRST_CLUST + CLUST_COUNT (32-bit wrap allowed).
  - sec = FIRST_CLUST >> log2(ENTRIES_PER_SECTOR).
  - last = (EOF − 1) >> log2(ENTRIES_PER_SECTOR).
- CLUST_COUNT = 0: no fill and no write; DONE pulses 1 cycle after START.
- Per sector:
  - UPD_BEGIN_CLUST = sec·ENTRIES_PER_SECTOR + 1.
  - UPD_EOF_CLUST = EOF.
  - WR_LBA = FAT_BEGIN_LBA + sec.
- States and transitions:
  - IDLE: START → ARM (or → FIN when CLUST_COUNT = 0).
  - ARM: UPD_ENA=0 for 2 cycles, so the fill stage resets its counters; then → FILL.
  - FILL: UPD_ENA=1; on UPD_COMPLT=1 → DRAIN.
  - DRAIN: UPD_ENA stays 1 for exactly 2 more cycles so the final buffer write lands; then → WRITE.
  - WRITE: UPD_ENA=0, WR_REQ=1.
    - WR_ACK → MIRROR (macro on) or NEXT.
    - WR_ERR → FAIL.
  - MIRROR: WR_REQ=1 with WR_LBA += FAT_SIZE_SECTORS; WR_ACK → NEXT; WR_ERR → FAIL.
  - NEXT: if sec == last → FIN; else sec += 1 → ARM.
  - FIN: DONE=1 for one cycle → IDLE.
  - FAIL: ERROR=1 → IDLE.
- WR_ACK and WR_ERR in the same cycle: WR_ERR wins.
- WR_ACK/WR_ERR outside WRITE/MIRROR and UPD_COMPLT outside FILL: ignored.
- START while BUSY: ignored; latched values are unchanged.
- Reset mid-operation: all outputs return to reset values immediately. The fill stage is disabled because UPD_ENA=0.

## Timing
- Reset values: UPD_ENA=0, UPD_BEGIN_CLUST=0, UPD_EOF_CLUST=0, WR_REQ=0, WR_LBA=0, BUSY=0, DONE=0, ERROR=0.
- All outputs are registered.
- START at edge n:
  - BUSY=1 and ARM from n+1.
  - UPD_ENA rises at n+3.
- UPD_COMPLT seen at edge m → UPD_ENA falls at m+3 and WR_REQ rises at m+3.
- WR_REQ falls the cycle after WR_ACK. The next sector's ARM starts 1 cycle after NEXT.
- DONE pulses the cycle BUSY falls.
- UPD_BEGIN_CLUST, UPD_EOF_CLUST and WR_LBA are stable from ARM entry until that sector leaves WRITE/MIRROR.

## Configuration
- FAT_MIRROR_EN defined: every FAT sector is written twice, at LBA and at LBA + FAT_SIZE_SECTORS (second FAT copy). The MIRROR state exists.
- FAT_MIRROR_EN undefined: MIRROR state and the adder are removed; one write per sector. FAT_SIZE_SECTORS is unused.

## Structure
- Shared package `fat_pkg` holds:
  - the state encoding;
  - ENTRIES_PER_SECTOR and its log2;
  - the FAT32 EOF marker constant 32'hFFFF_FFFF;
  - the sector-size constant 512.
- One natural sub-module, `fat_sector_span`: combinational/registered computation of the first/last sector index and EOF from FIRST_CLUST/CLUST_COUNT, latched on START.

## Test plan
- FIRST_CLUST=2, CLUST_COUNT=10, FAT_BEGIN_LBA=100 → one sector:
  - UPD_BEGIN_CLUST=1, UPD_EOF_CLUST=12;
  - WR_LBA=100, one WR_REQ, DONE once.
- FIRST_CLUST=120, CLUST_COUNT=20 → two sectors:
  - UPD_BEGIN_CLUST 1 then 129;
  - WR_LBA 100 then 101; EOF=140 both times.
- CLUST_COUNT=0 → no UPD_ENA, no WR_REQ, DONE 1 cycle after START.
- WR_ERR on the first write → ERROR=1, BUSY=0, no second fill; next START clears ERROR.
- With FAT_MIRROR_EN and FAT_SIZE_SECTORS=1024, one sector → WR_LBA 100 then 1124, then DONE.
- RST_N low during FILL → UPD_ENA=0 and BUSY=0 asynchronously; a following START runs the sequence from ARM.
